id_stage_fwd: RTL
=================

// Module: id_stage_fwd
// PURPOSE
//  Parametrised decode stage: decodes one MIPS32 instruction per cycle, drives the regfile read
//  ports, resolves operands via an N-source forwarding network, detects load-use hazards and
//  owns the ID/EX pipeline register. Sits between the IF/ID register and ex; stall/flush
//  come from the pipeline controller.
// PARAMETERS
//  DATA_W     32  operand / regfile data width
//  REG_AW     5   register address width
//  FWD_PORTS  2   forwarding sources; index 0 = EX (highest priority), higher = older stages
//  ALUOP_W    8   width of aluop field (matches AluOpBus)
//  ALUSEL_W   3   width of alusel field (matches AluSelBus)
//  CNT_W      16  width of stall-cycle counter
// PORTS
//  clk               in   1                   clock; all state on rising edge
//  rst               in   1                   synchronous, active-high reset
//  id_valid_i        in   1                   inst_i/pc_i hold a real instruction
//  pc_i              in   32                  instruction address
//  inst_i            in   32                  instruction word
//  reg1_read_o       out  1                   regfile port 1 read enable (comb)
//  reg1_addr_o       out  REG_AW              regfile port 1 address = inst_i[25:21] (comb)
//  reg1_data_i       in   DATA_W              regfile port 1 data
//  reg2_read_o       out  1                   regfile port 2 read enable (comb)
//  reg2_addr_o       out  REG_AW              regfile port 2 address = inst_i[20:16] (comb)
//  reg2_data_i       in   DATA_W              regfile port 2 data
//  fwd_wreg_i        in   FWD_PORTS           per-source write enable
//  fwd_wd_i          in   FWD_PORTS*REG_AW    per-source dest addr, source k at [k*REG_AW +: REG_AW]
//  fwd_wdata_i       in   FWD_PORTS*DATA_W    per-source result data
//  ex_is_load_i      in   1                   instruction in EX (source 0) is a load
//  stall_i           in   1                   hold ID/EX register
//  flush_i           in   1                   kill: load bubble into ID/EX
//  stallreq_o        out  1                   load-use stall request (comb)
//  ex_valid_o, ex_pc_o[31:0], ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o
//                    out  -                   registered ID/EX fields
//  ex_inst_invalid_o out  1                   registered: valid slot held an undecodable inst
//  stall_cnt_o       out  CNT_W               cycles with stallreq_o=1, saturating
// BEHAVIOUR
//  - Decode set: SPECIAL(sa=0) OR/AND/XOR/NOR/ADDU/SUBU; SPECIAL(rs=0) SLL/SRL/SRA; ORI/ANDI/XORI
//    zero-ext imm; ADDIU sign-ext imm; LUI imm={inst[15:0],16'h0}. Immediate replaces reg2;
//    shifts: reg1=zero-ext sa, reg2=rt. R-type wd=inst[15:11], I-type wd=inst[20:16].
//  - Unrecognised op with id_valid_i=1: wreg=0, aluop/alusel=NOP, ex_inst_invalid_o=1 next cycle.
//  - Operand select per port: read disabled -> imm; addr==0 -> 0 (never forwarded); else lowest k
//    with fwd_wreg_i[k] && fwd_wd_i[k]==addr -> fwd_wdata_i[k]; else regfile data.
//  - Load-use: stallreq_o = id_valid_i & ex_is_load_i & fwd_wreg_i[0] & (fwd_wd_i[0]!=0) &
//    ((reg1_read_o & addr1 match) | (reg2_read_o & addr2 match)).
//  - ID/EX update priority per edge: rst > flush_i > stall_i (hold) > stallreq_o (bubble) > load.
//    Bubble = ex_valid_o=0, ex_wreg_o=0, aluop/alusel=NOP, data/pc/wd=0, invalid=0.
//  - Latency: decode at edge N -> ex_* valid after edge N+1. id_valid_i=0 loads a bubble.
//  - stall_cnt_o: +1 per cycle stallreq_o=1 (even under stall_i), saturates at all-ones.
//  - Reset: all ex_* outputs = bubble values, stall_cnt_o=0. Comb read outputs ignore rst.
//  - Reset or flush mid-stall: bubble loaded; stallreq_o re-evaluates next cycle from inputs.
// STRUCTURE
//  - defines.v: opcode/funct constants, EXE_*_OP / EXE_RES_* codes, RstEnable, NOPRegAddr.
//  - Sub-module id_fwd_mux (#DATA_W,REG_AW,FWD_PORTS): one per operand; priority forwarding.
//  - This module: decode always block, hazard logic, ID/EX register, stall counter.
// TESTING
//  - Reset: rst=1 two cycles -> ex_valid_o=0, ex_wreg_o=0, stall_cnt_o=0.
//  - ORI $1,$0,0x8000 -> next cycle ex_reg1_o=0, ex_reg2_o=0x00008000, ex_wd_o=1, ex_wreg_o=1.
//  - ADDIU $2,$1,-1; fwd0 wreg=1 wd=1 data=5 and fwd1 wd=1 data=9 -> ex_reg1_o=5, reg2=FFFFFFFF.
//  - OR $3,$0,$0 with fwd0 wd=0 data=7 -> ex_reg1_o=ex_reg2_o=0.
//  - ex_is_load_i=1, fwd0 wd=4, inst AND $5,$4,$6 -> stallreq_o=1, bubble loaded, stall_cnt_o=1.
//  - Same hazard with stall_i=1 -> ID/EX held; flush_i=1 with valid ORI -> ex_valid_o=0.

Source files
------------

// File: rtl/id_stage_fwd_pkg.sv
// Shared decode constants for the MIPS32 decode stage: opcode/funct fields,
// ALU operation and result-select codes, reset level and the null register.
package id_stage_fwd_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  // ALU operation codes
  localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b00100001;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b00100011;
  localparam logic [7:0] EXE_ADDIU_OP = 8'b01010110;
  localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;

  // ALU result-select codes
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  localparam logic       RST_ENABLE   = 1'b1;
  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

  // How the immediate operand is formed from the instruction word
  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_ZEXT,
    IMM_SEXT,
    IMM_LUI,
    IMM_SA
  } imm_kind_e;

endpackage

// File: rtl/id_stage_fwd_mux.sv
// One operand selector: immediate when the port is not read, zero for $0,
// otherwise the youngest matching forwarding source, else regfile data.
module id_fwd_mux #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int FWD_PORTS = 2
) (
  input  logic                          read_en,
  input  logic [REG_AW-1:0]             addr,
  input  logic [DATA_W-1:0]             imm,
  input  logic [DATA_W-1:0]             rf_data,
  input  logic [FWD_PORTS-1:0]          fwd_wreg,
  input  logic [FWD_PORTS*REG_AW-1:0]   fwd_wd,
  input  logic [FWD_PORTS*DATA_W-1:0]   fwd_wdata,
  output logic [DATA_W-1:0]             operand
);

  logic hit;

  // Priority select; source 0 (EX) wins over older stages
  always_comb begin
    operand = rf_data;
    hit     = 1'b0;
    for (int k = 0; k < FWD_PORTS; k++) begin
      if (!hit && fwd_wreg[k] && (fwd_wd[k*REG_AW +: REG_AW] == addr)) begin
        operand = fwd_wdata[k*DATA_W +: DATA_W];
        hit     = 1'b1;
      end
    end
    if (addr == '0) operand = '0;
    if (!read_en)   operand = imm;
  end

endmodule

// File: rtl/id_stage_fwd.sv
// Decode stage: instruction decode, regfile read control, operand forwarding,
// load-use hazard detection, ID/EX pipeline register and stall-cycle counter.
module id_stage_fwd
  import id_stage_fwd_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int FWD_PORTS = 2,
  parameter int ALUOP_W   = 8,
  parameter int ALUSEL_W  = 3,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid_i,
  input  logic [31:0]                 pc_i,
  input  logic [31:0]                 inst_i,
  output logic                        reg1_read_o,
  output logic [REG_AW-1:0]           reg1_addr_o,
  input  logic [DATA_W-1:0]           reg1_data_i,
  output logic                        reg2_read_o,
  output logic [REG_AW-1:0]           reg2_addr_o,
  input  logic [DATA_W-1:0]           reg2_data_i,
  input  logic [FWD_PORTS-1:0]        fwd_wreg_i,
  input  logic [FWD_PORTS*REG_AW-1:0] fwd_wd_i,
  input  logic [FWD_PORTS*DATA_W-1:0] fwd_wdata_i,
  input  logic                        ex_is_load_i,
  input  logic                        stall_i,
  input  logic                        flush_i,
  output logic                        stallreq_o,
  output logic                        ex_valid_o,
  output logic [31:0]                 ex_pc_o,
  output logic [ALUOP_W-1:0]          ex_aluop_o,
  output logic [ALUSEL_W-1:0]         ex_alusel_o,
  output logic [DATA_W-1:0]           ex_reg1_o,
  output logic [DATA_W-1:0]           ex_reg2_o,
  output logic [REG_AW-1:0]           ex_wd_o,
  output logic                        ex_wreg_o,
  output logic                        ex_inst_invalid_o,
  output logic [CNT_W-1:0]            stall_cnt_o
);

  logic [5:0]          op;
  logic [5:0]          funct;
  logic                sa_zero;
  logic                rs_zero;
  logic                rtype;
  logic                shift;
  logic                itype;
  logic                known;
  logic [ALUOP_W-1:0]  aluop;
  logic [ALUSEL_W-1:0] alusel;
  logic [REG_AW-1:0]   wd;
  logic                wreg;
  imm_kind_e           imm_kind;
  logic [DATA_W-1:0]   imm;
  logic [DATA_W-1:0]   opnd1;
  logic [DATA_W-1:0]   opnd2;
  logic [REG_AW-1:0]   load_wd;
  logic                kill;

  assign op          = inst_i[31:26];
  assign funct       = inst_i[5:0];
  assign sa_zero     = (inst_i[10:6] == 5'd0);
  assign rs_zero     = (inst_i[25:21] == 5'd0);
  assign reg1_addr_o = REG_AW'(inst_i[25:21]);
  assign reg2_addr_o = REG_AW'(inst_i[20:16]);

  // Instruction decode; anything outside the supported set stays a NOP
  always_comb begin
    rtype    = 1'b0;
    shift    = 1'b0;
    itype    = 1'b0;
    aluop    = ALUOP_W'(EXE_NOP_OP);
    alusel   = ALUSEL_W'(EXE_RES_NOP);
    imm_kind = IMM_NONE;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_OR:   if (sa_zero) begin rtype = 1'b1; aluop = ALUOP_W'(EXE_OR_OP);   alusel = ALUSEL_W'(EXE_RES_LOGIC); end
          FN_AND:  if (sa_zero) begin rtype = 1'b1; aluop = ALUOP_W'(EXE_AND_OP);  alusel = ALUSEL_W'(EXE_RES_LOGIC); end
          FN_XOR:  if (sa_zero) begin rtype = 1'b1; aluop = ALUOP_W'(EXE_XOR_OP);  alusel = ALUSEL_W'(EXE_RES_LOGIC); end
          FN_NOR:  if (sa_zero) begin rtype = 1'b1; aluop = ALUOP_W'(EXE_NOR_OP);  alusel = ALUSEL_W'(EXE_RES_LOGIC); end
          FN_ADDU: if (sa_zero) begin rtype = 1'b1; aluop = ALUOP_W'(EXE_ADDU_OP); alusel = ALUSEL_W'(EXE_RES_ARITH); end
          FN_SUBU: if (sa_zero) begin rtype = 1'b1; aluop = ALUOP_W'(EXE_SUBU_OP); alusel = ALUSEL_W'(EXE_RES_ARITH); end
          FN_SLL:  if (rs_zero) begin shift = 1'b1; aluop = ALUOP_W'(EXE_SLL_OP);  alusel = ALUSEL_W'(EXE_RES_SHIFT); end
          FN_SRL:  if (rs_zero) begin shift = 1'b1; aluop = ALUOP_W'(EXE_SRL_OP);  alusel = ALUSEL_W'(EXE_RES_SHIFT); end
          FN_SRA:  if (rs_zero) begin shift = 1'b1; aluop = ALUOP_W'(EXE_SRA_OP);  alusel = ALUSEL_W'(EXE_RES_SHIFT); end
          default: ;
        endcase
        if (shift) imm_kind = IMM_SA;
      end
      OP_ORI:   begin itype = 1'b1; imm_kind = IMM_ZEXT; aluop = ALUOP_W'(EXE_OR_OP);    alusel = ALUSEL_W'(EXE_RES_LOGIC); end
      OP_ANDI:  begin itype = 1'b1; imm_kind = IMM_ZEXT; aluop = ALUOP_W'(EXE_AND_OP);   alusel = ALUSEL_W'(EXE_RES_LOGIC); end
      OP_XORI:  begin itype = 1'b1; imm_kind = IMM_ZEXT; aluop = ALUOP_W'(EXE_XOR_OP);   alusel = ALUSEL_W'(EXE_RES_LOGIC); end
      OP_ADDIU: begin itype = 1'b1; imm_kind = IMM_SEXT; aluop = ALUOP_W'(EXE_ADDIU_OP); alusel = ALUSEL_W'(EXE_RES_ARITH); end
      OP_LUI:   begin itype = 1'b1; imm_kind = IMM_LUI;  aluop = ALUOP_W'(EXE_OR_OP);    alusel = ALUSEL_W'(EXE_RES_LOGIC); end
      default: ;
    endcase
  end

  // Read enables, destination and the immediate operand
  always_comb begin
    known       = rtype | shift | itype;
    reg1_read_o = rtype | itype;
    reg2_read_o = rtype | shift;
    wreg        = known;
    if (rtype || shift) wd = REG_AW'(inst_i[15:11]);
    else if (itype)     wd = REG_AW'(inst_i[20:16]);
    else                wd = REG_AW'(NOP_REG_ADDR);
    case (imm_kind)
      IMM_ZEXT: imm = DATA_W'(inst_i[15:0]);
      IMM_SEXT: imm = {{(DATA_W-16){inst_i[15]}}, inst_i[15:0]};
      IMM_LUI:  imm = DATA_W'({inst_i[15:0], 16'h0000});
      IMM_SA:   imm = DATA_W'(inst_i[10:6]);
      default:  imm = '0;
    endcase
  end

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_PORTS(FWD_PORTS)) u_fwd1 (
    .read_en(reg1_read_o), .addr(reg1_addr_o), .imm(imm), .rf_data(reg1_data_i),
    .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i), .fwd_wdata(fwd_wdata_i), .operand(opnd1)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_PORTS(FWD_PORTS)) u_fwd2 (
    .read_en(reg2_read_o), .addr(reg2_addr_o), .imm(imm), .rf_data(reg2_data_i),
    .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i), .fwd_wdata(fwd_wdata_i), .operand(opnd2)
  );

  // Load-use hazard: the load in EX targets a register this instruction reads
  always_comb begin
    load_wd    = fwd_wd_i[REG_AW-1:0];
    stallreq_o = id_valid_i & ex_is_load_i & fwd_wreg_i[0] & (load_wd != '0) &
                 ((reg1_read_o & (load_wd == reg1_addr_o)) |
                  (reg2_read_o & (load_wd == reg2_addr_o)));
  end

  // A bubble is loaded on reset/flush, or when not held and the slot is empty or hazarded
  assign kill = (rst == RST_ENABLE) | flush_i | (~stall_i & (stallreq_o | ~id_valid_i));

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (kill) begin
      ex_valid_o        <= 1'b0;
      ex_pc_o           <= '0;
      ex_aluop_o        <= ALUOP_W'(EXE_NOP_OP);
      ex_alusel_o       <= ALUSEL_W'(EXE_RES_NOP);
      ex_reg1_o         <= '0;
      ex_reg2_o         <= '0;
      ex_wd_o           <= REG_AW'(NOP_REG_ADDR);
      ex_wreg_o         <= 1'b0;
      ex_inst_invalid_o <= 1'b0;
    end else if (!stall_i) begin
      ex_valid_o        <= 1'b1;
      ex_pc_o           <= pc_i;
      ex_aluop_o        <= aluop;
      ex_alusel_o       <= alusel;
      ex_reg1_o         <= opnd1;
      ex_reg2_o         <= opnd2;
      ex_wd_o           <= wd;
      ex_wreg_o         <= wreg;
      ex_inst_invalid_o <= ~known;
    end
  end

  // Saturating count of cycles spent requesting a load-use stall
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE)                  stall_cnt_o <= '0;
    else if (stallreq_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
  end

endmodule
